lfsr_stream_checker: RTL and testbench

//  Downstream consumer of the configurable 8-bit Fibonacci LFSR generator.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/lfsr_stream_checker.sv | 127 ++++++++++++
 tb/tb_lfsr_stream_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS LFSR generator and the stream checker.
// Holds the default register width and the checker state encoding.
package lfsr_pkg;

    localparam int LFSR_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear-then-increment when both are set.
// Latency: q updates on the edge that samples inc/clr; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising PRBS checker: predicts each received bit from the tap mask, reports lock and errors.
// Latency: locked/error/err_count change 1 cycle after the deciding valid bit; no backpressure, bit_valid qualifies input.
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int LFSR_W      = LFSR_W_DEFAULT,
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic [LFSR_W-1:0]    tap,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 zero_state
);

    localparam int FILL_W = (LFSR_W > 2)      ? $clog2(LFSR_W)      : 1;
    localparam int GOOD_W = (LOCK_COUNT > 2)  ? $clog2(LOCK_COUNT)  : 1;
    localparam int BAD_W  = (LOSS_THRESH > 2) ? $clog2(LOSS_THRESH) : 1;

    chk_state_t        state, state_nxt;
    logic [LFSR_W-1:0] sr, sr_nxt, tap_q;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [GOOD_W-1:0] good, good_nxt;
    logic [BAD_W-1:0]  bad, bad_nxt;
    logic              pred, mismatch, tap_chg, err_hit, error_q;

    assign tap_chg  = (tap != tap_q);
    assign pred     = ^(tap_q & sr);
    assign mismatch = bit_valid & (pred != bit_in);

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        fill_nxt  = fill;
        good_nxt  = good;
        bad_nxt   = bad;
        err_hit   = 1'b0;
        if (tap_chg) begin
            // A new polynomial invalidates everything learned so far; the bit is dropped.
            state_nxt = ACQ;
            fill_nxt  = '0;
            good_nxt  = '0;
        end else if (bit_valid) begin
            sr_nxt = {sr[LFSR_W-2:0], bit_in};
            case (state)
                ACQ: begin
                    if (fill == FILL_W'(LFSR_W - 1)) begin
                        state_nxt = VERIFY;
                        fill_nxt  = '0;
                        good_nxt  = '0;
                    end else begin
                        fill_nxt = fill + 1'b1;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        good_nxt = '0;
                    end else if (good == GOOD_W'(LOCK_COUNT - 1)) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                        bad_nxt   = '0;
                    end else begin
                        good_nxt = good + 1'b1;
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        err_hit = 1'b1;
                        if (bad == BAD_W'(LOSS_THRESH - 1)) begin
                            state_nxt = ACQ;
                            fill_nxt  = '0;
                            bad_nxt   = '0;
                        end else begin
                            bad_nxt = bad + 1'b1;
                        end
                    end else begin
                        bad_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ACQ;
                    fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ACQ;
            sr      <= '0;
            tap_q   <= '0;
            fill    <= '0;
            good    <= '0;
            bad     <= '0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            tap_q   <= tap;
            fill    <= fill_nxt;
            good    <= good_nxt;
            bad     <= bad_nxt;
            error_q <= err_hit;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (reset),
        .inc (err_hit),
        .clr (clear_cnt),
        .q   (err_count)
    );

    assign locked     = (state == LOCKED);
    assign error      = error_q;
    assign zero_state = locked & (sr == '0);

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: generator model drives the stream, a bit-history model predicts outputs.
module tb_lfsr_stream_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] tap;
    logic       clear_cnt;
    logic       locked, error, zero_state;
    logic [15:0] err_count;
    logic       locked_b, error_b, zero_state_b;
    logic [2:0] err_count_b;

    always #5 clk = ~clk;

    lfsr_stream_checker dut_a (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .tap(tap),
        .clear_cnt(clear_cnt), .locked(locked), .error(error), .err_count(err_count),
        .zero_state(zero_state)
    );

    lfsr_stream_checker #(.ERR_CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .tap(tap),
        .clear_cnt(clear_cnt), .locked(locked_b), .error(error_b), .err_count(err_count_b),
        .zero_state(zero_state_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the last 8 received bits (index 0 = newest) and streak counters.
    bit         m_hist[$];
    logic [7:0] m_tapq;
    int         m_seen, m_streak, m_miss, m_cnt16, m_cnt3;
    bit         m_lock, m_err;
    logic [7:0] gen;

    function automatic void model_reset();
        m_hist.delete();
        repeat (8) m_hist.push_back(1'b0);
        m_tapq = 8'h00;
        m_seen = 0; m_streak = 0; m_miss = 0; m_cnt16 = 0; m_cnt3 = 0;
        m_lock = 1'b0; m_err = 1'b0;
    endfunction

    function automatic bit hist_zero();
        foreach (m_hist[k]) if (m_hist[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(input bit v, input bit b, input logic [7:0] t, input bit clr);
        bit pred = 1'b0;
        bit miss;
        m_err = 1'b0;
        if (t != m_tapq) begin
            m_lock = 1'b0; m_seen = 0; m_streak = 0;
        end else if (v) begin
            for (int k = 0; k < 8; k++) if (m_tapq[k]) pred ^= m_hist[k];
            miss = (pred != b);
            if (m_lock) begin
                if (miss) begin
                    m_err = 1'b1;
                    m_miss++;
                    if (m_miss == 4) begin m_lock = 1'b0; m_seen = 0; end
                end else m_miss = 0;
            end else if (m_seen < 8) begin
                m_seen++; m_streak = 0;
            end else begin
                m_streak = miss ? 0 : m_streak + 1;
                if (m_streak == 16) begin m_lock = 1'b1; m_miss = 0; end
            end
            m_hist.push_front(b);
            void'(m_hist.pop_back());
        end
        m_tapq = t;
        if (clr) begin m_cnt16 = 0; m_cnt3 = 0; end
        if (m_err) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt3 < 7) m_cnt3++;
        end
    endfunction

    task automatic compare_all();
        check("locked",       32'(locked),      32'(m_lock));
        check("locked_w3",    32'(locked_b),    32'(m_lock));
        check("error",        32'(error),       32'(m_err));
        check("err_count",    32'(err_count),   32'(m_cnt16));
        check("err_count_w3", 32'(err_count_b), 32'(m_cnt3));
        check("zero_state",   32'(zero_state),  32'(m_lock && hist_zero()));
    endtask

    task automatic cycle(input bit v, input bit inv, input logic [7:0] t, input bit clr);
        tap       = t;
        bit_valid = v;
        clear_cnt = clr;
        bit_in    = v ? (gen[0] ^ inv) : 1'($urandom);
        @(posedge clk);
        model_step(v, bit_in, t, clr);
        if (v) gen = {gen[6:0], ^(t & gen)};
        #1;
        compare_all();
    endtask

    task automatic acquire_check(input string nm);
        cycle(1'b0, 1'b0, 8'hB8, 1'b0);
        repeat (23) cycle(1'b1, 1'b0, 8'hB8, 1'b0);
        check({nm, "_locked_after_23"}, 32'(locked), 32'd0);
        cycle(1'b1, 1'b0, 8'hB8, 1'b0);
        check({nm, "_locked_after_24"}, 32'(locked), 32'd1);
        check({nm, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    typedef struct {
        string      name;
        int         ncyc;
        logic [7:0] tap;
        logic [7:0] inv_mask;
        int         clr_at;
        logic       exp_locked;
        int         exp_a;
        int         exp_b;
        logic       exp_zero;
    } vec_t;

    vec_t       tbl[11];
    logic [7:0] tap_set[4] = '{8'hB8, 8'h8E, 8'hE1, 8'h00};

    initial begin
        tbl[0]  = '{"single_flip",  12, 8'hB8, 8'b0000_0100, -1, 1'b1, 5, 5, 1'b0};
        tbl[1]  = '{"burst4",        5, 8'hB8, 8'b0001_1110, -1, 1'b0, 9, 7, 1'b0};
        tbl[2]  = '{"relock_23",    23, 8'hB8, 8'b0000_0000, -1, 1'b0, 9, 7, 1'b0};
        tbl[3]  = '{"relock_24",     1, 8'hB8, 8'b0000_0000, -1, 1'b1, 9, 7, 1'b0};
        tbl[4]  = '{"tap_change",    1, 8'h8E, 8'b0000_0000, -1, 1'b0, 9, 7, 1'b0};
        tbl[5]  = '{"newtap_23",    23, 8'h8E, 8'b0000_0000, -1, 1'b0, 9, 7, 1'b0};
        tbl[6]  = '{"newtap_24",     1, 8'h8E, 8'b0000_0000, -1, 1'b1, 9, 7, 1'b0};
        tbl[7]  = '{"clr_with_err",  3, 8'h8E, 8'b0000_0100,  2, 1'b1, 1, 1, 1'b0};
        tbl[8]  = '{"clr_tail",     10, 8'h8E, 8'b0000_0000, -1, 1'b1, 5, 5, 1'b0};
        tbl[9]  = '{"drop_again",    4, 8'h8E, 8'b0000_1011, -1, 1'b0, 9, 7, 1'b0};
        tbl[10] = '{"tap_zero",     25, 8'h00, 8'b0000_0000, -1, 1'b1, 9, 7, 1'b1};

        reset = 1'b1; tap = 8'hB8; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;
        gen = 8'h01;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked",    32'(locked),     32'd0);
        check("reset_error",     32'(error),      32'd0);
        check("reset_err_count", 32'(err_count),  32'd0);
        check("reset_zero",      32'(zero_state), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        acquire_check("acq");

        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < tbl[i].ncyc; c++) begin
                cycle(1'b1, (c < 8) ? tbl[i].inv_mask[c] : 1'b0, tbl[i].tap, c == tbl[i].clr_at);
            end
            check({tbl[i].name, "_locked"},    32'(locked),      32'(tbl[i].exp_locked));
            check({tbl[i].name, "_cnt"},       32'(err_count),   32'(tbl[i].exp_a));
            check({tbl[i].name, "_cnt_w3"},    32'(err_count_b), 32'(tbl[i].exp_b));
            check({tbl[i].name, "_zero"},      32'(zero_state),  32'(tbl[i].exp_zero));
        end

        // Reset asserted between edges while verifying, with a non-zero error count.
        gen = 8'h01;
        repeat (13) cycle(1'b1, 1'b0, 8'hB8, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_locked",    32'(locked),      32'd0);
        check("async_error",     32'(error),       32'd0);
        check("async_err_count", 32'(err_count),   32'd0);
        check("async_err_w3",    32'(err_count_b), 32'd0);
        check("async_zero",      32'(zero_state),  32'd0);
        model_reset();
        gen = 8'h01;
        @(negedge clk);
        reset = 1'b0;
        acquire_check("reacq");

        begin
            logic [7:0] cur_tap;
            cur_tap = 8'hB8;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 299) == 0) begin
                    cur_tap = tap_set[$urandom_range(0, 3)];
                    if (cur_tap != 8'h00 && gen == 8'h00) gen = 8'h5A;
                end
                cycle($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0, cur_tap,
                      $urandom_range(0, 149) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
